// File: rtl/gp_sum_pkg.sv
// Shared constants, triple type and group lookahead helper for the
// generate/half-sum/propagate carry resolver.
package gp_sum_pkg;

    localparam int WIDTH   = 6;
    localparam int GROUP   = 3;
    localparam int NGROUPS = WIDTH / GROUP;

    // One bit-cell result: generate, half-sum, propagate.
    typedef struct packed {
        logic g;
        logic h;
        logic p;
    } triple_t;

    // Group generate (ripple of g through p, LSB first) and group propagate.
    // Returns {G, P}.
    function automatic logic [1:0] group_gp(input logic [GROUP-1:0] g,
                                            input logic [GROUP-1:0] p);
        logic v_g;
        logic v_p;
        v_g = 1'b0;
        v_p = 1'b1;
        for (int k = 0; k < GROUP; k++) begin
            v_g = g[k] | (p[k] & v_g);
            v_p = v_p & p[k];
        end
        return {v_g, v_p};
    endfunction

endpackage

// File: rtl/gp_sum_resolver_if.sv
// Stream bundle around the resolver: triple vector in, resolved sum out.
// master = surrounding datapath (upstream producer + downstream consumer),
// slave  = the resolver itself.
interface gp_sum_resolver_if #(
    parameter int WIDTH = gp_sum_pkg::WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] g_in;
    logic [WIDTH-1:0] h_in;
    logic [WIDTH-1:0] p_in;
    logic             cin;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, g_in, h_in, p_in, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, g_in, h_in, p_in, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/gp_group_carry.sv
// In-group carry ripple and sum bits for one lookahead group.
// Generate is rebuilt as p & ~h so only h and p need to be carried.
module gp_group_carry #(
    parameter int GROUP = gp_sum_pkg::GROUP
) (
    input  logic [GROUP-1:0] i_h,
    input  logic [GROUP-1:0] i_p,
    input  logic             i_cin,
    output logic [GROUP-1:0] o_sum
);

    logic w_c;

    // Ripple the group carry-in across the group, producing each sum bit.
    always_comb begin
        w_c   = i_cin;
        o_sum = '0;
        for (int k = 0; k < GROUP; k++) begin
            o_sum[k] = i_h[k] ^ w_c;
            w_c      = (i_p[k] & ~i_h[k]) | (i_p[k] & w_c);
        end
    end

endmodule

// File: rtl/gp_sum_resolver.sv
// Two-stage carry resolver: stage 1 registers h/p/cin and group G/P,
// stage 2 resolves group and in-group carries into sum/cout/ovf.
// Valid/ready ready-chain with no skid buffer; sticky illegal-triple flag.
module gp_sum_resolver
    import gp_sum_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    gp_sum_resolver_if.slave bus,
    input  logic             err_clr,
    output logic             err
);

    // Handshake / control
    logic                 w_s2_adv;
    logic                 w_s1_adv;
    logic                 w_accept;
    logic                 w_illegal;

    // Input stage combinational
    triple_t [WIDTH-1:0]  w_trip;
    logic [WIDTH-1:0]     w_g_rec_p0;
    logic [NGROUPS-1:0]   w_G_p0;
    logic [NGROUPS-1:0]   w_P_p0;

    // Stage 1 registers
    logic                 r_vld_p1;
    logic [WIDTH-1:0]     r_h_p1;
    logic [WIDTH-1:0]     r_p_p1;
    logic                 r_cin_p1;
    logic [NGROUPS-1:0]   r_G_p1;
    logic [NGROUPS-1:0]   r_P_p1;

    // Stage 2 combinational
    logic [NGROUPS:0]     w_C_p1;
    logic [WIDTH-1:0]     w_sum_p1;
    logic                 w_ovf_p1;

    // Stage 2 (output) registers
    logic                 r_vld_p2;
    logic [WIDTH-1:0]     r_sum_p2;
    logic                 r_cout_p2;
    logic                 r_ovf_p2;
    logic                 r_err;

    assign w_s2_adv     = !r_vld_p2 || bus.out_ready;
    assign w_s1_adv     = !r_vld_p1 || w_s2_adv;
    assign w_accept     = bus.in_valid && w_s1_adv;
    assign bus.in_ready = w_s1_adv;

    // ---- p0: incoming triples, legality and group lookahead ----
    for (genvar k = 0; k < WIDTH; k++) begin : g_trip
        assign w_trip[k].g = bus.g_in[k];
        assign w_trip[k].h = bus.h_in[k];
        assign w_trip[k].p = bus.p_in[k];
    end

    // Generate recovered from h/p so an illegal vector still resolves from h and p alone.
    assign w_g_rec_p0 = bus.p_in & ~bus.h_in;

    // Flag any bit whose triple cannot come from a real x/y pair.
    always_comb begin
        w_illegal = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            if ((w_trip[k].g & ~w_trip[k].p) |
                (w_trip[k].h & ~w_trip[k].p) |
                (w_trip[k].g &  w_trip[k].h) |
                (w_trip[k].p & ~w_trip[k].g & ~w_trip[k].h)) begin
                w_illegal = 1'b1;
            end
        end
    end

    // Per-group generate/propagate.
    always_comb begin
        w_G_p0 = '0;
        w_P_p0 = '0;
        for (int i = 0; i < NGROUPS; i++) begin
            {w_G_p0[i], w_P_p0[i]} = group_gp(w_g_rec_p0[i*GROUP +: GROUP],
                                              bus.p_in[i*GROUP +: GROUP]);
        end
    end

    // ---- p1: stage 1 registers ----
    // Stage 1 valid moves whenever stage 1 may advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
        end else if (w_s1_adv) begin
            r_vld_p1 <= bus.in_valid;
        end
    end

    // Stage 1 data captured only on an accepted transfer.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_h_p1   <= bus.h_in;
            r_p_p1   <= bus.p_in;
            r_cin_p1 <= bus.cin;
            r_G_p1   <= w_G_p0;
            r_P_p1   <= w_P_p0;
        end
    end

    // Group carry-ins from the registered lookahead terms.
    always_comb begin
        w_C_p1    = '0;
        w_C_p1[0] = r_cin_p1;
        for (int i = 0; i < NGROUPS; i++) begin
            w_C_p1[i+1] = r_G_p1[i] | (r_P_p1[i] & w_C_p1[i]);
        end
    end

    for (genvar i = 0; i < NGROUPS; i++) begin : g_grp
        gp_group_carry #(
            .GROUP (GROUP)
        ) u_grp (
            .i_h   (r_h_p1[i*GROUP +: GROUP]),
            .i_p   (r_p_p1[i*GROUP +: GROUP]),
            .i_cin (w_C_p1[i]),
            .o_sum (w_sum_p1[i*GROUP +: GROUP])
        );
    end

    // Carry into the MSB is recovered from its sum bit: c = sum ^ h.
    assign w_ovf_p1 = w_C_p1[NGROUPS] ^ w_sum_p1[WIDTH-1] ^ r_h_p1[WIDTH-1];

    // ---- p2: output registers ----
    // Output stage loads a new result whenever the consumer frees it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p2  <= 1'b0;
            r_sum_p2  <= '0;
            r_cout_p2 <= 1'b0;
            r_ovf_p2  <= 1'b0;
        end else if (w_s2_adv) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_sum_p2  <= w_sum_p1;
                r_cout_p2 <= w_C_p1[NGROUPS];
                r_ovf_p2  <= w_ovf_p1;
            end
        end
    end

    // Sticky error: a new illegal accept beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept && w_illegal) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign bus.out_valid = r_vld_p2;
    assign bus.sum       = r_sum_p2;
    assign bus.cout      = r_cout_p2;
    assign bus.ovf       = r_ovf_p2;
    assign err           = r_err;

endmodule

// File: tb/tb_gp_sum_resolver.sv
// Directed bench for gp_sum_resolver with an in-order result scoreboard.
module tb_gp_sum_resolver;
    import gp_sum_pkg::*;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_clr = 1'b0;
    logic err;

    gp_sum_resolver_if bus_if ();

    gp_sum_resolver dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus_if),
        .err_clr (err_clr),
        .err     (err)
    );

    always #5 clk = ~clk;

    res_t             exp_q[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    res_t             mon_e;
    res_t             held;
    logic             held_v = 1'b0;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;

    // Reference: legal triple means x|y plus x&y; illegal vectors use p and p&~h.
    function automatic res_t model(input logic [WIDTH-1:0] h,
                                   input logic [WIDTH-1:0] p,
                                   input logic c);
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH:0]   r;
        res_t             o;
        a = p;
        b = p & ~h;
        r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
        o.sum  = r[WIDTH-1:0];
        o.cout = r[WIDTH];
        o.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one vector; commits to the scoreboard only when ready is seen just before the edge.
    task automatic send(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] h,
                        input logic [WIDTH-1:0] p, input logic c);
        int n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        bus_if.g_in     = g;
        bus_if.h_in     = h;
        bus_if.p_in     = p;
        bus_if.cin      = c;
        bus_if.in_valid = 1'b1;
        while (!ok && n < 40) begin
            @(negedge clk);
            if (bus_if.in_ready) ok = 1'b1;
            n++;
        end
        if (!ok) check("send_ready_timeout", {31'd0, bus_if.in_ready}, 32'd1);
        else exp_q.push_back(model(h, p, c));
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
    endtask

    task automatic send_xy(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        send(a & b, a ^ b, a | b, c);
    endtask

    // Output monitor: pops the scoreboard on each transfer and checks stall stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (held_v) begin
                check("hold_valid", {31'd0, bus_if.out_valid}, 32'd1);
                check("hold_data", {24'd0, bus_if.sum, bus_if.cout, bus_if.ovf}, {24'd0, held});
            end
            if (bus_if.out_valid && bus_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_sum", {26'd0, bus_if.sum}, {26'd0, mon_e.sum});
                    check("out_cout", {31'd0, bus_if.cout}, {31'd0, mon_e.cout});
                    check("out_ovf", {31'd0, bus_if.ovf}, {31'd0, mon_e.ovf});
                end
            end
            held_v = bus_if.out_valid && !bus_if.out_ready;
            held   = {bus_if.sum, bus_if.cout, bus_if.ovf};
        end else begin
            held_v = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.g_in      = '0;
        bus_if.h_in      = '0;
        bus_if.p_in      = '0;
        bus_if.cin       = 1'b0;
        bus_if.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("rst_sum", {26'd0, bus_if.sum}, 32'd0);
        check("rst_cout", {31'd0, bus_if.cout}, 32'd0);
        check("rst_ovf", {31'd0, bus_if.ovf}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);

        // 11+7 with latency check
        send(6'b000011, 6'b001100, 6'b001111, 1'b0);
        check("lat_stage1", {31'd0, bus_if.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_stage2", {31'd0, bus_if.out_valid}, 32'd1);
        check("plan_sum_11_7", {26'd0, bus_if.sum}, {26'd0, 6'b010010});
        @(posedge clk);
        #1;
        check("lat_drained", {31'd0, bus_if.out_valid}, 32'd0);

        // Full-width ripple, signed overflow, cin-only, then random legal traffic back to back
        send(6'b000001, 6'b111110, 6'b111111, 1'b0);
        send(6'b000001, 6'b011110, 6'b011111, 1'b0);
        send(6'b000000, 6'b000000, 6'b000000, 1'b1);
        for (int i = 0; i < 8; i++) begin
            x = 6'($urandom);
            y = 6'($urandom);
            send_xy(x, y, 1'($urandom));
        end
        repeat (4) @(posedge clk);
        #1;
        check("drain_basic", 32'(exp_q.size()), 32'd0);
        check("err_legal", {31'd0, err}, 32'd0);

        // Backpressure: two accepts fill the pipe, stall 3 cycles
        send_xy(6'd20, 6'd9, 1'b0);
        send_xy(6'd33, 6'd40, 1'b1);
        bus_if.out_ready = 1'b0;
        #1;
        check("bp_in_ready_low", {31'd0, bus_if.in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, bus_if.out_valid}, 32'd1);
        fork
            send_xy(6'd63, 6'd63, 1'b1);
            begin
                repeat (2) @(posedge clk);
                #1;
                check("bp_still_blocked", {31'd0, bus_if.in_ready}, 32'd0);
                @(posedge clk);
                #1;
                bus_if.out_ready = 1'b1;
            end
        join
        send_xy(6'd5, 6'd58, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("drain_bp", 32'(exp_q.size()), 32'd0);

        // Illegal triple: sticky error, clear, and set-beats-clear
        send(6'b000100, 6'b000100, 6'b000100, 1'b0);
        check("err_set", {31'd0, err}, 32'd1);
        send_xy(6'd7, 6'd12, 1'b0);
        send_xy(6'd60, 6'd3, 1'b1);
        check("err_sticky", {31'd0, err}, 32'd1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("err_cleared", {31'd0, err}, 32'd0);
        err_clr = 1'b1;
        send(6'b000000, 6'b000000, 6'b100000, 1'b0);
        err_clr = 1'b0;
        check("err_set_wins", {31'd0, err}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("drain_illegal", 32'(exp_q.size()), 32'd0);

        // Reset with both stages occupied
        bus_if.out_ready = 1'b0;
        send_xy(6'd17, 6'd2, 1'b0);
        send(6'b010000, 6'b000000, 6'b000000, 1'b0);
        #1;
        check("mid_full_valid", {31'd0, bus_if.out_valid}, 32'd1);
        check("mid_full_ready", {31'd0, bus_if.in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("mid_rst_err", {31'd0, err}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus_if.out_ready = 1'b1;
        send_xy(6'd44, 6'd25, 1'b1);
        check("post_rst_stage1", {31'd0, bus_if.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("post_rst_valid", {31'd0, bus_if.out_valid}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("drain_final", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
